// File: rtl/memory_bus_arbiter.sv
// Two-port front end for memory_system. Each port latches its own request,
// one downstream transaction runs at a time, and a watchdog aborts stuck transfers.

module memory_bus_arbiter_port (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        dispatch_read,
    input  logic        dispatch_write,
    input  logic [1:0]  mem_width,
    input  logic        clear,
    input  logic        load_read,
    input  logic [31:0] load_value,
    output logic        pending,
    output logic        req_read,
    output logic [31:0] req_addr,
    output logic [31:0] req_write_data,
    output logic [1:0]  req_width,
    output logic [31:0] read_data,
    output logic        busy
);
    logic capture;

    // A dispatch while a request is already held is dropped on the floor.
    assign capture = !pending && (dispatch_read || dispatch_write);
    assign busy    = pending | dispatch_read | dispatch_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending        <= 1'b0;
            req_read       <= 1'b0;
            req_addr       <= '0;
            req_write_data <= '0;
            req_width      <= '0;
            read_data      <= '0;
        end else begin
            if (capture) begin
                pending        <= 1'b1;
                req_read       <= dispatch_read;
                req_addr       <= addr;
                req_write_data <= write_data;
                req_width      <= mem_width;
            end else if (clear) begin
                pending <= 1'b0;
            end
            if (load_read) read_data <= load_value;
        end
    end
endmodule

module memory_bus_arbiter #(
    parameter int          FIXED_PRIORITY = 0,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ABORT_DATA     = 32'hDEAD_BEEF
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_write_data,
    input  logic        m0_dispatch_read,
    input  logic        m0_dispatch_write,
    input  logic [1:0]  m0_mem_width,
    output logic [31:0] m0_read_data,
    output logic        m0_busy,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_write_data,
    input  logic        m1_dispatch_read,
    input  logic        m1_dispatch_write,
    input  logic [1:0]  m1_mem_width,
    output logic [31:0] m1_read_data,
    output logic        m1_busy,
    output logic [31:0] s_addr,
    output logic [31:0] s_write_data,
    output logic        s_dispatch_read,
    output logic        s_dispatch_write,
    output logic [1:0]  s_mem_width,
    input  logic [31:0] s_read_data,
    input  logic        s_busy,
    output logic        timeout_flag
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    state_t           state, state_nxt;
    logic             grant, grant_nxt, last_grant, first_wait, done, abort;
    logic [CW-1:0]    wd_cnt;
    logic [31:0]      load_value;
    logic [1:0][31:0] in_addr, in_wdata, req_addr, req_wdata, rd_data;
    logic [1:0][1:0]  in_width, req_width;
    logic [1:0]       in_rd, in_wr, pend, req_read, busy, clear, load;

    assign in_addr  = {m1_addr, m0_addr};
    assign in_wdata = {m1_write_data, m0_write_data};
    assign in_width = {m1_mem_width, m0_mem_width};
    assign in_rd    = {m1_dispatch_read, m0_dispatch_read};
    assign in_wr    = {m1_dispatch_write, m0_dispatch_write};
    assign load_value = done ? s_read_data : ABORT_DATA;

    for (genvar i = 0; i < 2; i++) begin : g_port
        assign clear[i] = (done || abort) && (grant == 1'(i));
        assign load[i]  = clear[i] && req_read[i];
        memory_bus_arbiter_port u_port (
            .clk(clk_in), .rst_n(rst_n_in),
            .addr(in_addr[i]), .write_data(in_wdata[i]),
            .dispatch_read(in_rd[i]), .dispatch_write(in_wr[i]), .mem_width(in_width[i]),
            .clear(clear[i]), .load_read(load[i]), .load_value(load_value),
            .pending(pend[i]), .req_read(req_read[i]), .req_addr(req_addr[i]),
            .req_write_data(req_wdata[i]), .req_width(req_width[i]),
            .read_data(rd_data[i]), .busy(busy[i])
        );
    end

    assign m0_read_data = rd_data[0];
    assign m1_read_data = rd_data[1];
    assign m0_busy      = busy[0];
    assign m1_busy      = busy[1];
    // Downstream bus always reflects the granted request, so it stays stable through WAIT_DONE.
    assign s_addr       = req_addr[grant];
    assign s_write_data = req_wdata[grant];
    assign s_mem_width  = req_width[grant];

    always_comb begin
        state_nxt        = state;
        grant_nxt        = grant;
        done             = 1'b0;
        abort            = 1'b0;
        s_dispatch_read  = 1'b0;
        s_dispatch_write = 1'b0;
        case (state)
            IDLE: begin
                if (|pend) begin
                    state_nxt = ISSUE;
                    if (&pend) grant_nxt = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant;
                    else       grant_nxt = pend[1];
                end
            end
            ISSUE: begin
                s_dispatch_read  = req_read[grant];
                s_dispatch_write = !req_read[grant];
                state_nxt        = WAIT_DONE;
            end
            WAIT_DONE: begin
                // s_busy is still high from our own dispatch on the first cycle.
                if (!first_wait && !s_busy) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (TIMEOUT_CYCLES > 0 && wd_cnt == WD_LAST) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state        <= IDLE;
            grant        <= 1'b0;
            last_grant   <= 1'b0;
            first_wait   <= 1'b0;
            wd_cnt       <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            first_wait <= (state == ISSUE);
            if (state == ISSUE)          wd_cnt <= '0;
            else if (state == WAIT_DONE) wd_cnt <= wd_cnt + 1'b1;
            if (done)  last_grant   <= grant;
            if (abort) timeout_flag <= 1'b1;
        end
    end
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Scoreboard bench: one round-robin/watchdog arbiter and one fixed-priority arbiter
// share the same consumer stimulus, each against its own memory model.

module tb_memory_bus_arbiter;
    localparam int ND = 2;   // 0: round-robin, TIMEOUT=8   1: fixed priority, no watchdog
    localparam logic [31:0] ABORT = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  width;
        logic        rd;
        int          cap;
    } req_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0, errors = 0;

    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic        m0_rd = 0, m0_wr = 0, m1_rd = 0, m1_wr = 0;
    logic [1:0]  m0_w = '0, m1_w = '0;

    logic [31:0] m0_rd_o [ND];
    logic [31:0] m1_rd_o [ND];
    logic        m0_busy_o [ND];
    logic        m1_busy_o [ND];
    logic [31:0] s_addr_o [ND];
    logic [31:0] s_wdata_o [ND];
    logic        s_dr_o [ND];
    logic        s_dw_o [ND];
    logic [1:0]  s_w_o [ND];
    logic [31:0] s_rdata [ND];
    logic        tflag [ND];
    logic        s_busy_rr, s_busy_fp;

    req_t        req_q [ND][2][$];
    logic [31:0] resp_q [ND][2][$];
    int          out_cnt [ND][2];
    logic [31:0] last_rd [ND][2];
    bit          last_g [ND];
    bit          prev_busy [ND][2];
    int          lat_pick [ND];
    int          bcnt [ND];
    bit          stuck_req [ND];
    bit          stuck_now [ND];
    int          disp_cnt [ND];
    int          fixed_lat = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    memory_bus_arbiter #(.FIXED_PRIORITY(0), .TIMEOUT_CYCLES(8)) u_rr (
        .clk_in(clk), .rst_n_in(rst_n),
        .m0_addr(m0_addr), .m0_write_data(m0_wdata), .m0_dispatch_read(m0_rd),
        .m0_dispatch_write(m0_wr), .m0_mem_width(m0_w), .m0_read_data(m0_rd_o[0]), .m0_busy(m0_busy_o[0]),
        .m1_addr(m1_addr), .m1_write_data(m1_wdata), .m1_dispatch_read(m1_rd),
        .m1_dispatch_write(m1_wr), .m1_mem_width(m1_w), .m1_read_data(m1_rd_o[0]), .m1_busy(m1_busy_o[0]),
        .s_addr(s_addr_o[0]), .s_write_data(s_wdata_o[0]), .s_dispatch_read(s_dr_o[0]),
        .s_dispatch_write(s_dw_o[0]), .s_mem_width(s_w_o[0]), .s_read_data(s_rdata[0]),
        .s_busy(s_busy_rr), .timeout_flag(tflag[0])
    );

    memory_bus_arbiter #(.FIXED_PRIORITY(1), .TIMEOUT_CYCLES(0)) u_fp (
        .clk_in(clk), .rst_n_in(rst_n),
        .m0_addr(m0_addr), .m0_write_data(m0_wdata), .m0_dispatch_read(m0_rd),
        .m0_dispatch_write(m0_wr), .m0_mem_width(m0_w), .m0_read_data(m0_rd_o[1]), .m0_busy(m0_busy_o[1]),
        .m1_addr(m1_addr), .m1_write_data(m1_wdata), .m1_dispatch_read(m1_rd),
        .m1_dispatch_write(m1_wr), .m1_mem_width(m1_w), .m1_read_data(m1_rd_o[1]), .m1_busy(m1_busy_o[1]),
        .s_addr(s_addr_o[1]), .s_write_data(s_wdata_o[1]), .s_dispatch_read(s_dr_o[1]),
        .s_dispatch_write(s_dw_o[1]), .s_mem_width(s_w_o[1]), .s_read_data(s_rdata[1]),
        .s_busy(s_busy_fp), .timeout_flag(tflag[1])
    );

    // Memory model: busy through the dispatch cycle plus lat cycles, or forever when stuck.
    assign s_busy_rr = s_dr_o[0] | s_dw_o[0] | (bcnt[0] != 0) | stuck_now[0];
    assign s_busy_fp = s_dr_o[1] | s_dw_o[1] | (bcnt[1] != 0) | stuck_now[1];

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < ND; d++) begin
            if (!rst_n) begin
                bcnt[d]      <= 0;
                stuck_now[d] <= 1'b0;
            end else if (s_dr_o[d] || s_dw_o[d]) begin
                bcnt[d]      <= lat_pick[d];
                stuck_now[d] <= stuck_req[d];
            end else if (bcnt[d] > 0) begin
                bcnt[d] <= bcnt[d] - 1;
            end
        end
    end

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        if (a == 32'h1000_0004) return 32'hCAFE_F00D;
        return {a[15:0], ~a[31:16]} ^ 32'h0F0F_3C3C;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: grant choice is derived from the queued requests old enough to be
    // pending in the arbitration cycle, then the issued fields and completions are checked.
    task automatic mon(input int d);
        bit          busy [2];
        logic [31:0] rdv [2];
        bit          el [2];
        int          g;
        req_t        r;
        logic [31:0] e;
        busy[0] = m0_busy_o[d]; busy[1] = m1_busy_o[d];
        rdv[0]  = m0_rd_o[d];   rdv[1]  = m1_rd_o[d];
        if (s_dr_o[d] || s_dw_o[d]) begin
            disp_cnt[d]++;
            for (int i = 0; i < 2; i++)
                el[i] = (req_q[d][i].size() > 0) && (req_q[d][i][0].cap <= cyc - 2);
            if (!el[0] && !el[1]) begin
                chk($sformatf("d%0d_unexpected_dispatch", d), {30'b0, s_dr_o[d], s_dw_o[d]}, 32'h0);
            end else begin
                if (el[0] && el[1]) g = (d == 1) ? 0 : (last_g[d] ? 0 : 1);
                else                g = el[1] ? 1 : 0;
                r = req_q[d][g].pop_front();
                chk($sformatf("d%0d_p%0d_s_addr", d, g), s_addr_o[d], r.addr);
                chk($sformatf("d%0d_p%0d_s_op", d, g), {30'b0, s_dr_o[d], s_dw_o[d]}, {30'b0, r.rd, !r.rd});
                chk($sformatf("d%0d_p%0d_s_width", d, g), {30'b0, s_w_o[d]}, {30'b0, r.width});
                if (!r.rd) chk($sformatf("d%0d_p%0d_s_wdata", d, g), s_wdata_o[d], r.data);
                lat_pick[d] = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 5));
                s_rdata[d]  = r.rd ? rd_val(r.addr) : $urandom;
                if (r.rd) begin
                    e = stuck_req[d] ? ABORT : rd_val(r.addr);
                    last_rd[d][g] = e;
                end else begin
                    e = last_rd[d][g];
                end
                resp_q[d][g].push_back(e);
                if (!stuck_req[d]) last_g[d] = (g == 1);
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (prev_busy[d][i] && !busy[i]) begin
                if (resp_q[d][i].size() == 0) begin
                    chk($sformatf("d%0d_p%0d_unexpected_completion", d, i), {31'b0, busy[i]}, 32'h1);
                end else begin
                    e = resp_q[d][i].pop_front();
                    chk($sformatf("d%0d_p%0d_read_data", d, i), rdv[i], e);
                    out_cnt[d][i]--;
                end
            end
            prev_busy[d][i] = busy[i];
        end
    endtask

    always @(negedge clk) if (rst_n) for (int d = 0; d < ND; d++) mon(d);

    task automatic tick();
        @(posedge clk);
        #1;
        m0_rd = 0; m0_wr = 0; m1_rd = 0; m1_wr = 0;
        #1;
    endtask

    function automatic bit idle_port(input int p);
        return out_cnt[0][p] == 0 && out_cnt[1][p] == 0;
    endfunction

    task automatic drive(input int p, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] dt, input logic [1:0] w);
        if (p == 0) begin m0_addr = a; m0_wdata = dt; m0_w = w; m0_rd = rd; m0_wr = wr; end
        else        begin m1_addr = a; m1_wdata = dt; m1_w = w; m1_rd = rd; m1_wr = wr; end
    endtask

    task automatic issue(input int p, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] dt, input logic [1:0] w);
        req_t r;
        r.addr = a; r.data = dt; r.width = w; r.rd = rd; r.cap = cyc;
        drive(p, rd, wr, a, dt, w);
        for (int d = 0; d < ND; d++) begin
            req_q[d][p].push_back(r);
            out_cnt[d][p]++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(idle_port(0) && idle_port(1)) && n < 300) begin tick(); n++; end
        chk("drain_outstanding", 32'(out_cnt[0][0] + out_cnt[0][1] + out_cnt[1][0] + out_cnt[1][1]), 32'h0);
    endtask

    task automatic rand_phase(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (idle_port(p)) begin
                    if ($urandom_range(0, 2) == 0) begin
                        int sel = int'($urandom_range(0, 7));
                        issue(p, sel >= 2, sel <= 2, $urandom & 32'hFFFF_FFFC, $urandom,
                              2'($urandom_range(0, 2)));
                    end
                end else if ((p == 0 ? (m0_busy_o[0] && m0_busy_o[1]) : (m1_busy_o[0] && m1_busy_o[1]))
                             && $urandom_range(0, 7) == 0) begin
                    drive(p, 1'b1, 1'b0, $urandom, $urandom, 2'd2);   // protocol violation, must be ignored
                end
            end
        end
    endtask

    task automatic reset_model();
        for (int d = 0; d < ND; d++) begin
            last_g[d] = 0; stuck_req[d] = 0;
            for (int p = 0; p < 2; p++) begin
                req_q[d][p].delete(); resp_q[d][p].delete();
                out_cnt[d][p] = 0; last_rd[d][p] = '0; prev_busy[d][p] = 0;
            end
        end
    endtask

    initial begin
        int dc;
        reset_model();
        for (int d = 0; d < ND; d++) begin lat_pick[d] = 0; s_rdata[d] = '0; disp_cnt[d] = 0; end
        repeat (3) tick();
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("d%0d_reset_rd0", d), m0_rd_o[d], 32'h0);
            chk($sformatf("d%0d_reset_busy", d), {30'b0, m0_busy_o[d], m1_busy_o[d]}, 32'h0);
            chk($sformatf("d%0d_reset_disp", d), {30'b0, s_dr_o[d], s_dw_o[d]}, 32'h0);
            chk($sformatf("d%0d_reset_tflag", d), {31'b0, tflag[d]}, 32'h0);
        end
        rst_n = 1'b1;
        repeat (2) tick();

        // Single DWORD read with 4 busy cycles after the dispatch cycle
        fixed_lat = 4;
        issue(0, 1, 0, 32'h1000_0004, 32'h0, 2'd2);
        #1 chk("busy_same_cycle", {31'b0, m0_busy_o[0]}, 32'h1);
        tick(); chk("no_dispatch_n1", {31'b0, s_dr_o[0]}, 32'h0);
        tick(); chk("dispatch_n2", {31'b0, s_dr_o[0]}, 32'h1);
        tick(); chk("pulse_one_cycle", {31'b0, s_dr_o[0]}, 32'h0);
        repeat (3) tick();
        chk("s_busy_high_n6", {31'b0, s_busy_rr}, 32'h1);
        tick();
        chk("s_busy_low_n7", {31'b0, s_busy_rr}, 32'h0);
        chk("m_busy_held_n7", {31'b0, m0_busy_o[0]}, 32'h1);
        tick();
        chk("m_busy_fall_n8", {31'b0, m0_busy_o[0]}, 32'h0);
        chk("read_cafe", m0_rd_o[0], 32'hCAFE_F00D);
        fixed_lat = -1;
        wait_idle();

        // Simultaneous requests: round-robin serves port1 first, fixed priority port0
        tick();
        issue(0, 1, 0, 32'h0000_0100, 32'h0, 2'd2);
        issue(1, 1, 0, 32'h0000_0200, 32'h0, 2'd2);
        wait_idle();

        // Port1 WORD write while port0 read pending; simultaneous rd+wr resolves to read
        tick(); issue(0, 1, 1, 32'h0000_0300, 32'h1111_2222, 2'd2);
        tick(); issue(1, 0, 1, 32'h2000_0000, 32'h0000_F800, 2'd1);
        tick(); drive(0, 1'b1, 1'b0, 32'h0BAD_0000, 32'h0, 2'd0);
        wait_idle();

        // Watchdog: s_busy stuck high on the round-robin instance
        stuck_req[0] = 1;
        tick(); issue(0, 1, 0, 32'h3000_0010, 32'h0, 2'd2);
        repeat (10) tick();
        chk("wd_busy_before_abort", {31'b0, m0_busy_o[0]}, 32'h1);
        chk("wd_flag_before_abort", {31'b0, tflag[0]}, 32'h0);
        tick();
        chk("wd_busy_after_abort", {31'b0, m0_busy_o[0]}, 32'h0);
        chk("wd_flag_set", {31'b0, tflag[0]}, 32'h1);
        chk("wd_abort_data", m0_rd_o[0], ABORT);
        stuck_req[0] = 0;
        wait_idle();

        rand_phase(400);
        wait_idle();
        chk("wd_flag_sticky", {31'b0, tflag[0]}, 32'h1);
        chk("fp_flag_clear", {31'b0, tflag[1]}, 32'h0);

        // Asynchronous reset in the middle of WAIT_DONE
        fixed_lat = 5;
        tick(); issue(0, 1, 0, 32'h4000_0000, 32'h0, 2'd2);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("d%0d_arst_disp", d), {30'b0, s_dr_o[d], s_dw_o[d]}, 32'h0);
            chk($sformatf("d%0d_arst_busy", d), {30'b0, m0_busy_o[d], m1_busy_o[d]}, 32'h0);
            chk($sformatf("d%0d_arst_rd", d), m0_rd_o[d] | m1_rd_o[d], 32'h0);
            chk($sformatf("d%0d_arst_saddr", d), s_addr_o[d], 32'h0);
            chk($sformatf("d%0d_arst_tflag", d), {31'b0, tflag[d]}, 32'h0);
        end
        reset_model();
        fixed_lat = -1;
        repeat (2) tick();
        rst_n = 1'b1;
        dc = disp_cnt[0] + disp_cnt[1];
        repeat (6) tick();
        chk("post_reset_no_dispatch", 32'(disp_cnt[0] + disp_cnt[1]), 32'(dc));
        chk("post_reset_idle", {30'b0, m0_busy_o[0], m1_busy_o[0]}, 32'h0);

        rand_phase(150);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
